// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the sequential FIR MAC.
// FIR_ROUND_EN adds one guard bit to the accumulator for the rounding add.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } fir_state_e;

`ifdef FIR_ROUND_EN
    localparam int unsigned ROUND_GUARD = 1;
`else
    localparam int unsigned ROUND_GUARD = 0;
`endif

    function automatic int unsigned idx_w(input int unsigned num_taps);
        return (num_taps > 1) ? $clog2(num_taps) : 1;
    endfunction

    // Worst-case sum of num_taps full-width products, plus the rounding guard bit.
    function automatic int unsigned acc_w(input int unsigned num_taps,
                                          input int unsigned data_w,
                                          input int unsigned coef_w);
        return data_w + coef_w + $clog2(num_taps) + ROUND_GUARD;
    endfunction

    function automatic int unsigned unity_coef(input int unsigned coef_frac);
        return 32'd1 << coef_frac;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational scale-down of the accumulator to DATA_W with clipping.
// FIR_ROUND_EN selects round-half-up; otherwise the shift truncates (floor).
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int unsigned ACC_W     = 35,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_FRAC = 12
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_sat
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_biased;
    logic signed [ACC_W-1:0] w_shifted;

`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(64'd1 << (COEF_FRAC - 1));
    assign w_biased = i_acc + HALF_LSB;
`else
    assign w_biased = i_acc;
`endif

    assign w_shifted = w_biased >>> COEF_FRAC;

    always_comb begin
        o_sat  = 1'b1;
        o_data = SAT_MAX[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            o_data = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            o_data = SAT_MIN[DATA_W-1:0];
        end else begin
            o_data = w_shifted[DATA_W-1:0];
            o_sat  = 1'b0;
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR: one multiplier shared over NUM_TAPS cycles, clock-enable low-power hold.
// Define FIR_ROUND_EN for round-half-up output scaling instead of truncation.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAPS  = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned COEF_FRAC = 12
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        low_power_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_sat,
    input  logic                        coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
    input  logic [COEF_W-1:0]           coef_wr_data
);

    localparam int unsigned IDX_W    = idx_w(NUM_TAPS);
    localparam int unsigned ACC_W    = acc_w(NUM_TAPS, DATA_W, COEF_W);
    localparam int unsigned PROD_W   = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
    localparam logic [COEF_W-1:0] UNITY   = COEF_W'(unity_coef(COEF_FRAC));

    fir_state_e               r_state, w_state_d;
    logic signed [DATA_W-1:0] r_delay [NUM_TAPS];
    logic signed [COEF_W-1:0] r_coef  [NUM_TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_out_valid;
    logic                     r_out_sat;
    logic [DATA_W-1:0]        r_out_data;

    logic                     w_en;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_mac_step;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [DATA_W-1:0] w_rs_data;
    logic                     w_rs_sat;

    assign w_en     = !low_power_mode;
    assign w_accept = in_ready && in_valid;
    assign w_prod   = PROD_W'(r_delay[r_idx]) * PROD_W'(r_coef[r_idx]);

    always_comb begin
        w_state_d  = r_state;
        in_ready   = 1'b0;
        w_load     = 1'b0;
        w_mac_step = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = w_en;
                if (in_valid && w_en) w_state_d = MAC;
            end
            MAC: begin
                if (w_en) begin
                    w_mac_step = 1'b1;
                    if (r_idx == LAST_IDX) w_state_d = DONE;
                end
            end
            DONE: begin
                if (w_en && (!r_out_valid || out_ready)) begin
                    w_load    = 1'b1;
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_delay[k] <= '0;
                r_coef[k]  <= (k == 0) ? UNITY : '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_delay[0] <= data_in;
                for (int k = 1; k < NUM_TAPS; k++) r_delay[k] <= r_delay[k-1];
                r_acc <= '0;
                r_idx <= '0;
            end else if (w_mac_step) begin
                r_acc <= r_acc + ACC_W'(w_prod);
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            // Coefficient writes land regardless of the clock-enable, but only while idle.
            if (r_state == IDLE && coef_wr_en && (32'(coef_wr_addr) < NUM_TAPS)) begin
                r_coef[coef_wr_addr] <= coef_wr_data;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rs_data;
                r_out_sat   <= w_rs_sat;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    fir_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Parametrised successor to the team's fixed 4-tap low-power FIR.
- Replaces the flop-generated clock gate with a clock-enable: `low_power_mode` freezes all state on the single `clk`.
- Time-multiplexes one multiplier over `NUM_TAPS` cycles, with runtime-writable coefficients and a valid/ready stream on both sides.
- Sits between the sample source and downstream DSP in the low-power comparison datapath.

Parameters:
- NUM_TAPS, 4: filter length, ≥2.
- DATA_W, 16: signed input/output sample width.
- COEF_W, 16: signed coefficient width.
- COEF_FRAC, 12: coefficient fractional bits, Q(COEF_W-COEF_FRAC).COEF_FRAC, ≥1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- low_power_mode  in  1  1 = hold all internal state (clock-enable low).
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- data_in  in  DATA_W  signed sample.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  signed filtered result.
- out_sat  out  1  out_data was saturated; qualified by out_valid.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  $clog2(NUM_TAPS)  tap index.
- coef_wr_data  in  COEF_W  signed coefficient.

Behaviour:
- **Reset** (reset_n low, asynchronous):
  - state=IDLE; delay line, accumulator and tap index = 0; out_valid=0, out_data=0, out_sat=0.
  - coef[0]=2**COEF_FRAC (unity pass-through); all other coefs 0.
  - Asserting reset mid-operation aborts the operation; no partial output.
- **FSM states:** IDLE, MAC, DONE.
  - IDLE:
    - in_ready = !low_power_mode.
    - On accept: delay[k] <= delay[k-1], delay[0] <= data_in, acc <= 0, idx <= 0, go MAC.
  - MAC:
    - Each enabled cycle: acc += delay[idx]*coef[idx], idx++.
    - After the idx==NUM_TAPS-1 product, go DONE.
  - DONE:
    - If !out_valid | out_ready: load out_data/out_sat from the round/saturate result, out_valid <= 1, go IDLE.
    - Otherwise stall in DONE.
  - in_ready = 0 in MAC and DONE.
- **Latency:** NUM_TAPS+1 enabled cycles from the accept edge to out_valid high. Throughput is one sample per NUM_TAPS+2 cycles maximum.
- **Output handshake:**
  - out_valid stays high, and out_data/out_sat stay stable, until out_valid & out_ready.
  - The clear and a new load in the same cycle yields out_valid staying 1 with the new data.
- **Arithmetic:**
  - Product width is DATA_W+COEF_W.
  - ACC_W = DATA_W+COEF_W+$clog2(NUM_TAPS); no accumulator overflow is possible.
  - Result = acc >>> COEF_FRAC (arithmetic).
  - Saturate to [-2**(DATA_W-1), 2**(DATA_W-1)-1]; out_sat=1 if clipped.
- **low_power_mode=1:**
  - FSM, idx, acc, delay line and coef reads are frozen; in_ready=0.
  - The output handshake still completes (out_ready clears out_valid).
  - Deassertion resumes exactly where frozen; the result is bit-identical.
- **Coefficient writes:**
  - Take effect only in IDLE, independent of low_power_mode.
  - Ignored in MAC/DONE.
  - A write and a sample accept in the same IDLE cycle: the new coef is used for that sample.

Optional Feature:
- FIR_ROUND_EN defined:
  - Add 2**(COEF_FRAC-1) to acc before the shift (round half up).
  - ACC_W grows by 1 so the add cannot overflow.
- Undefined: plain truncation (floor); no adder present.

Decomposition:
- Package fir_pkg holds:
  - state enum {IDLE, MAC, DONE};
  - ACC_W/index-width helper functions;
  - unity-coefficient constant function.
- Sub-module fir_round_sat:
  - combinational round (under FIR_ROUND_EN), shift and saturate;
  - parameters ACC_W, DATA_W, COEF_FRAC;
  - outputs the value plus a sat flag.

Test Plan (NUM_TAPS=4, DATA_W=16, COEF_W=16, COEF_FRAC=12):
- Post-reset, no coef writes, data_in=100 accepted, out_ready=1 -> out_data=100, out_sat=0, out_valid rises 5 cycles after accept.
- Write coefs 0x1000,0x2000,0x3000,0x1000; impulse 1000 then four zeros -> outputs 1000, 2000, 3000, 1000, 0.
- All coefs 0x1000; four samples of 30000 -> 4th output 32767, out_sat=1. Repeat with -30000 -> -32768, out_sat=1.
- out_ready=0 after first result; offer second sample -> accepted, FSM stalls in DONE, in_ready=0, first out_data stable; release out_ready -> second result appears the next cycle.
- low_power_mode high for 10 cycles mid-MAC -> same out_data as the unstalled run, latency 15; in_ready=0 throughout. A coef write mid-MAC is ignored (verify by readback via the next impulse).
- coef[0]=0x0800, data_in=3 then -3:
  - with FIR_ROUND_EN -> 2, then -1;
  - without -> 1, then -2.
- reset_n pulse during MAC -> out_valid 0 and coefs restored.
